// File: rtl/time_merger.sv
// BCD-to-binary time merger: rebuilds a binary count from ones/tens digits
// by adding 10 once per cycle, with start/busy/done/error handshake.
module time_merger #(
    parameter int BIT_WIDTH = 7,
    parameter int MAX_VALUE = 99
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [3:0]           i_time_1,
    input  logic [3:0]           i_time_10,
    output logic [BIT_WIDTH-1:0] o_time,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [6:0] MAX_ACC = 7'(MAX_VALUE);

    state_t               state_q, state_d;
    logic [6:0]           acc_q, acc_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [BIT_WIDTH-1:0] time_q, time_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 bad_digit;

    assign bad_digit = (i_time_1 > 4'd9) || (i_time_10 > 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            time_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            time_q  <= time_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        time_d  = time_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    acc_d   = {3'b000, i_time_1};
                    cnt_d   = i_time_10;
                    err_d   = bad_digit;
                    // Invalid digits and a zero tens digit skip accumulation.
                    state_d = (bad_digit || (i_time_10 == 4'd0)) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + 7'd10;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (err_q || (acc_q > MAX_ACC)) begin
                    error_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                    time_d = BIT_WIDTH'(acc_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_time  = time_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_time_merger.sv
// Bench for time_merger: two instances (99/7-bit and 59/6-bit) checked each
// cycle against a transaction-level model, plus directed literal scenarios.
module tb_time_merger;

    logic       clk = 1'b0;
    logic       reset;
    logic       st [2];
    logic [3:0] d1 [2];
    logic [3:0] d10 [2];
    logic [6:0] time0;
    logic [5:0] time1;
    logic       busy_o [2];
    logic       done_o [2];
    logic       err_o [2];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // model state
    int m_rem [2];
    int m_val [2];
    int m_time [2];
    bit m_bad [2];
    bit m_done [2];
    bit m_err [2];

    always #5 clk = ~clk;

    time_merger #(.BIT_WIDTH(7), .MAX_VALUE(99)) dut0 (
        .clk(clk), .reset(reset), .i_start(st[0]), .i_time_1(d1[0]), .i_time_10(d10[0]),
        .o_time(time0), .o_busy(busy_o[0]), .o_done(done_o[0]), .o_error(err_o[0])
    );

    time_merger #(.BIT_WIDTH(6), .MAX_VALUE(59)) dut1 (
        .clk(clk), .reset(reset), .i_start(st[1]), .i_time_1(d1[1]), .i_time_10(d10[1]),
        .o_time(time1), .o_busy(busy_o[1]), .o_done(done_o[1]), .o_error(err_o[1])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int maxv(input int i);
        return (i == 0) ? 99 : 59;
    endfunction

    function automatic int get_time(input int i);
        return (i == 0) ? int'(time0) : int'(time1);
    endfunction

    // Transaction model: a request finishes T+1 edges after acceptance
    // (1 edge if a digit is invalid); a new request is taken only when idle.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_val[i] = 0; m_time[i] = 0;
            m_bad[i] = 0; m_done[i] = 0; m_err[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (reset) begin
                    m_rem[i] = 0; m_time[i] = 0; m_done[i] = 0; m_err[i] = 0;
                end else begin
                    m_done[i] = 0;
                    m_err[i]  = 0;
                    if (m_rem[i] > 0) begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            if (m_bad[i]) m_err[i] = 1;
                            else begin
                                m_done[i] = 1;
                                m_time[i] = m_val[i];
                            end
                        end
                    end else if (st[i]) begin
                        bit inv;
                        inv = (d1[i] > 4'd9) || (d10[i] > 4'd9);
                        m_val[i] = 10 * int'(d10[i]) + int'(d1[i]);
                        m_bad[i] = inv || (m_val[i] > maxv(i));
                        m_rem[i] = inv ? 1 : int'(d10[i]) + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("busy%0d", i), int'(busy_o[i]), int'(m_rem[i] > 0));
                    check($sformatf("done%0d", i), int'(done_o[i]), int'(m_done[i]));
                    check($sformatf("error%0d", i), int'(err_o[i]), int'(m_err[i]));
                    check($sformatf("time%0d", i), get_time(i), m_time[i]);
                end
            end
        end
    end

    task automatic set_in(input int i, input bit s, input int o, input int t);
        st[i]  = s;
        d1[i]  = 4'(o);
        d10[i] = 4'(t);
    endtask

    // One request with literal expectations on latency, pulse and result.
    task automatic conv(input int i, input int ones, input int tens, input bit exp_err,
                        input int exp_time, input int exp_lat, input bit poke);
        int lat;
        int busyc;
        bit seen;
        @(posedge clk); #2;
        set_in(i, 1, ones, tens);
        @(posedge clk); #2;
        set_in(i, 0, 0, 0);
        lat = 0; busyc = 0; seen = 0;
        while (!seen && lat <= 20) begin
            if (done_o[i] || err_o[i]) seen = 1;
            else begin
                if (busy_o[i]) busyc++;
                if (poke && lat == 3) set_in(i, 1, 9, 9);
                else if (poke) set_in(i, 0, 0, 0);
                @(posedge clk); #2;
                lat++;
            end
        end
        if (!seen) begin
            check("conv_timeout", 0, 1);
            return;
        end
        check("conv_latency", lat, exp_lat);
        check("conv_busy_cycles", busyc, exp_lat);
        check("conv_done", int'(done_o[i]), int'(!exp_err));
        check("conv_error", int'(err_o[i]), int'(exp_err));
        check("conv_time", get_time(i), exp_time);
        check("conv_busy_at_pulse", int'(busy_o[i]), 0);
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        set_in(0, 0, 0, 0);
        set_in(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1;
        check("rst_time0", int'(time0), 0);
        check("rst_busy0", int'(busy_o[0]), 0);
        check("rst_done0", int'(done_o[0]), 0);
        check("rst_error0", int'(err_o[0]), 0);
        reset = 1'b0;

        conv(0, 2, 4, 0, 42, 5, 0);
        conv(0, 7, 0, 0, 7, 1, 0);
        conv(0, 9, 9, 0, 99, 10, 0);
        conv(0, 2, 4, 0, 42, 5, 0);
        conv(0, 3, 10, 1, 42, 1, 0);
        conv(0, 15, 1, 1, 42, 1, 0);

        conv(1, 0, 6, 1, 0, 7, 0);
        conv(1, 9, 5, 0, 59, 6, 0);
        conv(1, 0, 6, 1, 59, 7, 0);

        // start held high with 5,1: accept, one ACCUM, FINISH, then re-accept
        @(posedge clk); #2;
        set_in(0, 1, 5, 1);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #2;
            if (done_o[0]) begin
                ndone++;
                check("hold_time", int'(time0), 15);
            end
        end
        set_in(0, 0, 0, 0);
        check("hold_count", ndone, 4);

        // digits changed and start pulsed while busy must not disturb 84
        conv(0, 4, 8, 0, 84, 9, 1);
        @(posedge clk); #2;
        check("no_extra_start", int'(busy_o[0]), 0);

        // reset during the third ACCUM cycle aborts cleanly
        @(posedge clk); #2;
        set_in(0, 1, 1, 7);
        @(posedge clk); #2;
        set_in(0, 0, 0, 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        check("abort_busy", int'(busy_o[0]), 0);
        check("abort_time", int'(time0), 0);
        repeat (12) begin
            @(posedge clk); #2;
            check("abort_no_pulse", int'(done_o[0] || err_o[0]), 0);
        end

        repeat (600) begin
            @(posedge clk); #2;
            for (int i = 0; i < 2; i++) begin
                int o;
                int t;
                if ($urandom_range(0, 4) == 0) begin
                    o = $urandom_range(0, 15);
                    t = $urandom_range(0, 15);
                end else begin
                    o = $urandom_range(0, 9);
                    t = $urandom_range(0, 9);
                end
                set_in(i, ($urandom_range(0, 2) == 0), o, t);
            end
            reset = ($urandom_range(0, 149) == 0);
        end
        reset = 1'b0;
        set_in(0, 0, 0, 0);
        set_in(1, 0, 0, 0);
        repeat (15) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
